// File: rtl/ed_pkg.sv
// Shared types and constants for the energy-window accumulator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ed_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        PUSH  = 2'd1,
        END   = 2'd2
    } ed_state_t;

    localparam int          ED_DW        = 16;
    localparam int          ED_LOG2_WIN  = 10;
    localparam int          ED_EW        = 32;
    localparam int          ED_NRES      = 8;
    localparam logic [31:0] ED_THRESHOLD = 32'd1000;
    localparam int          ED_OVR_W     = 16;

    // Clamp a window mean to the largest value the EW-1 bit result field can hold.
    function automatic logic [63:0] sat_mean(input logic [63:0] mean, input int unsigned ew);
        logic [63:0] lim;
        lim = (64'd1 << (ew - 1)) - 64'd1;
        return (mean > lim) ? lim : mean;
    endfunction

endpackage

// File: rtl/energy_window_accumulator_if.sv
// Sample input / result FIFO bundle of the energy-window accumulator.
// Latency: none (wiring only).
// Backpressure: fifo_full from the result FIFO; samples have none (ED_OVERRUN_CNT_EN adds overrun_cnt).
interface energy_window_accumulator_if #(
    parameter int DW = ed_pkg::ED_DW,
    parameter int EW = ed_pkg::ED_EW
);
    logic                 sample_valid;
    logic signed [DW-1:0] i_in;
    logic signed [DW-1:0] q_in;
    logic                 fifo_full;
    logic                 push_fin;
    logic [EW-1:0]        din_fin;
    logic                 end_sig;
    logic                 overrun;
`ifdef ED_OVERRUN_CNT_EN
    logic [ed_pkg::ED_OVR_W-1:0] overrun_cnt;

    modport master (output sample_valid, i_in, q_in, fifo_full,
                    input  push_fin, din_fin, end_sig, overrun, overrun_cnt);
    modport slave  (input  sample_valid, i_in, q_in, fifo_full,
                    output push_fin, din_fin, end_sig, overrun, overrun_cnt);
`else
    modport master (output sample_valid, i_in, q_in, fifo_full,
                    input  push_fin, din_fin, end_sig, overrun);
    modport slave  (input  sample_valid, i_in, q_in, fifo_full,
                    output push_fin, din_fin, end_sig, overrun);
`endif
endinterface

// File: rtl/ed_square_sum.sv
// Registered I^2+Q^2 of one complex sample, with its valid bit.
// Latency: 1 cycle.
// Backpressure: none; a valid input always lands in the register.
module ed_square_sum #(
    parameter int DW = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid,
    input  logic signed [DW-1:0] i,
    input  logic signed [DW-1:0] q,
    output logic                 valid_d,
    output logic [2*DW:0]        sq
);
    logic signed [2*DW-1:0] ii;
    logic signed [2*DW-1:0] qq;

    // Squares are non-negative; the extra sum bit keeps -2^(DW-1) on both rails exact.
    assign ii = i * i;
    assign qq = q * q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_d <= 1'b0;
            sq      <= '0;
        end else begin
            valid_d <= valid;
            if (valid) begin
                sq <= {1'b0, ii} + {1'b0, qq};
            end
        end
    end
endmodule

// File: rtl/energy_window_accumulator.sv
// Windowed mean-energy detector feeding the result FIFO; end_sig after every NRES results.
// Latency: last window sample accepted at edge t -> push_fin high after edge t+2 (fifo_full=0).
// Backpressure: holds results while fifo_full; samples outside ACCUM are dropped (ED_OVERRUN_CNT_EN counts them).
module energy_window_accumulator
    import ed_pkg::*;
#(
    parameter int          DW        = ED_DW,
    parameter int          LOG2_WIN  = ED_LOG2_WIN,
    parameter int          EW        = ED_EW,
    parameter int          NRES      = ED_NRES,
    parameter logic [31:0] THRESHOLD = ED_THRESHOLD
) (
    input  logic                        clock,
    input  logic                        reset,
    energy_window_accumulator_if.slave  bus
);
    localparam int SQW  = 2 * DW + 1;
    localparam int ACCW = SQW + LOG2_WIN;
    localparam int RCW  = $clog2(NRES + 1);

    ed_state_t           state;
    logic [ACCW-1:0]     acc;
    logic [LOG2_WIN-1:0] sample_cnt;
    logic [RCW-1:0]      res_cnt;
    logic                s1_vld;
    logic [SQW-1:0]      sq;
    logic                push_fin_q;
    logic [EW-1:0]       din_fin_q;
    logic                end_sig_q;
    logic                overrun_q;
    logic                accept;
    logic                drop;
    logic [63:0]         mean;

    assign accept = bus.sample_valid && (state == ACCUM);
    assign drop   = bus.sample_valid && (state != ACCUM);
    assign mean   = 64'(acc >> LOG2_WIN);

    ed_square_sum #(.DW(DW)) u_sq (
        .clock   (clock),
        .reset   (reset),
        .valid   (accept),
        .i       (bus.i_in),
        .q       (bus.q_in),
        .valid_d (s1_vld),
        .sq      (sq)
    );

    // Leaving ACCUM on acceptance of the last sample closes the window exactly; PUSH then
    // waits for that sample to drain out of stage 1 so it is always counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ACCUM;
            acc        <= '0;
            sample_cnt <= '0;
            res_cnt    <= '0;
            push_fin_q <= 1'b0;
            din_fin_q  <= '0;
            end_sig_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            push_fin_q <= 1'b0;
            end_sig_q  <= 1'b0;
            if (drop) begin
                overrun_q <= 1'b1;
            end
            if (s1_vld) begin
                acc <= acc + ACCW'(sq);
            end
            case (state)
                ACCUM: begin
                    if (accept) begin
                        sample_cnt <= sample_cnt + LOG2_WIN'(1);
                        if (&sample_cnt) begin
                            state <= PUSH;
                        end
                    end
                end
                PUSH: begin
                    if (!s1_vld && !bus.fifo_full) begin
                        push_fin_q <= 1'b1;
                        din_fin_q  <= {mean > 64'(THRESHOLD), (EW-1)'(sat_mean(mean, EW))};
                        acc        <= '0;
                        sample_cnt <= '0;
                        res_cnt    <= res_cnt + RCW'(1);
                        state      <= (int'(res_cnt) + 1 >= NRES) ? END : ACCUM;
                    end
                end
                END: begin
                    end_sig_q <= 1'b1;
                    res_cnt   <= '0;
                    state     <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.push_fin = push_fin_q;
    assign bus.din_fin  = din_fin_q;
    assign bus.end_sig  = end_sig_q;
    assign bus.overrun  = overrun_q;

`ifdef ED_OVERRUN_CNT_EN
    logic [ED_OVR_W-1:0] ovr_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovr_cnt <= '0;
        end else if (drop && (ovr_cnt != {ED_OVR_W{1'b1}})) begin
            ovr_cnt <= ovr_cnt + ED_OVR_W'(1);
        end
    end

    assign bus.overrun_cnt = ovr_cnt;
`endif
endmodule

// File: tb/tb_energy_window_accumulator.sv
// Directed bench for energy_window_accumulator (LOG2_WIN=2, NRES=2, THRESHOLD=100).
// Latency: n/a.
// Backpressure: fifo_full driven directly by the stimulus.
module tb_energy_window_accumulator;
    import ed_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    energy_window_accumulator_if #(.DW(16), .EW(32)) bus ();

    energy_window_accumulator #(
        .DW        (16),
        .LOG2_WIN  (2),
        .EW        (32),
        .NRES      (2),
        .THRESHOLD (32'd100)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic feed(input int n, input logic signed [15:0] i, input logic signed [15:0] q);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            bus.sample_valid = 1'b1;
            bus.i_in         = i;
            bus.q_in         = q;
        end
        @(negedge clock);
        bus.sample_valid = 1'b0;
    endtask

    // Called on the negedge where input activity stops; lat counts negedges until push_fin.
    task automatic expect_push(input string tag, input int exp_lat, input logic [31:0] exp_din,
                               input logic exp_end);
        int lat;
        lat = 0;
        while (bus.push_fin !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_din"}, 64'(bus.din_fin), 64'(exp_din));
        @(negedge clock);
        check({tag, "_pulse"}, 64'(bus.push_fin), 64'd0);
        check({tag, "_end"}, 64'(bus.end_sig), 64'(exp_end));
        @(negedge clock);
        check({tag, "_end_off"}, 64'(bus.end_sig), 64'd0);
    endtask

    initial begin
        int pushes;
        reset            = 1'b1;
        bus.sample_valid = 1'b0;
        bus.i_in         = '0;
        bus.q_in         = '0;
        bus.fifo_full    = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_push", 64'(bus.push_fin), 64'd0);
        check("rst_din", 64'(bus.din_fin), 64'd0);
        check("rst_end", 64'(bus.end_sig), 64'd0);
        check("rst_ovr", 64'(bus.overrun), 64'd0);
`ifdef ED_OVERRUN_CNT_EN
        check("rst_ovr_cnt", 64'(bus.overrun_cnt), 64'd0);
`endif
        reset = 1'b0;

        // mean 100: equal to threshold, no detect
        feed(4, 16'sd10, 16'sd0);
        expect_push("t1", 2, 32'h0000_0064, 1'b0);
        // mean 101: detect; second result of the burst
        feed(4, 16'sd10, 16'sd1);
        expect_push("t2", 2, 32'h8000_0065, 1'b1);

        feed(4, 16'sd5, 16'sd5);
        expect_push("t3a", 2, 32'h0000_0032, 1'b0);
        feed(4, 16'sd20, 16'sd0);
        expect_push("t3b", 2, 32'h8000_0190, 1'b1);
        check("t3_ovr", 64'(bus.overrun), 64'd0);

        // 2^31 mean saturates to 2^31-1 with detect
        feed(4, -16'sd32768, -16'sd32768);
        expect_push("t4", 2, 32'hFFFF_FFFF, 1'b0);

        feed(4, 16'sd10, 16'sd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            bus.fifo_full    = 1'b1;
            bus.sample_valid = 1'b1;
            bus.i_in         = 16'sd1000;
            bus.q_in         = 16'sd0;
            check("t5_hold", 64'(bus.push_fin), 64'd0);
        end
        @(negedge clock);
        bus.fifo_full    = 1'b0;
        bus.sample_valid = 1'b0;
        check("t5_hold_last", 64'(bus.push_fin), 64'd0);
        expect_push("t5", 1, 32'h0000_0064, 1'b1);
        check("t5_ovr", 64'(bus.overrun), 64'd1);
`ifdef ED_OVERRUN_CNT_EN
        check("t5_ovr_cnt", 64'(bus.overrun_cnt), 64'd5);
`endif

        // partial window discarded by reset
        feed(2, 16'sd100, 16'sd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6_ovr_clr", 64'(bus.overrun), 64'd0);
`ifdef ED_OVERRUN_CNT_EN
        check("t6_ovr_cnt_clr", 64'(bus.overrun_cnt), 64'd0);
`endif
        reset  = 1'b0;
        pushes = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (bus.push_fin === 1'b1) pushes++;
        end
        check("t6_no_push", 64'(pushes), 64'd0);
        feed(4, 16'sd3, 16'sd4);
        expect_push("t6", 2, 32'h0000_0019, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
